aap_fetch_assembler: RTL and testbench

Fetch stage directly upstream of the 16/32-bit decoder. Streams 16-bit words from a synchronous instruction memory into a small prefetch FIFO. Assembles one instruction at a time into a registered output: one word when bit 15 is 0, two words when bit 15 of the first word is 1. Hands the instruction to the decoder with a valid/ready handshake and supports a single-cycle branch redirect.

---
 rtl/aap_fetch_assembler.sv | 140 ++++++++++++++
 tb/tb_aap_fetch_assembler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aap_fetch_assembler.sv
// Fetch stage: streams 16-bit words into a prefetch FIFO and assembles 16/32-bit instructions.
// Define FETCH_PERF_EN to add the perf_instr_count / perf_stall_count outputs.
module aap_fetch_assembler #(
   parameter int                    PC_WIDTH   = 24,
   parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  imem_rd,
   output logic [PC_WIDTH-1:0]   imem_addr,
   input  logic [15:0]           imem_rdata,
   input  logic                  redirect_valid,
   input  logic [PC_WIDTH-1:0]   redirect_pc,
   output logic                  fetch_valid,
   input  logic                  decode_ready,
   output logic [31:0]           fetch_instr,
   output logic                  fetch_is32,
   output logic [PC_WIDTH-1:0]   fetch_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]           perf_instr_count,
   output logic [31:0]           perf_stall_count
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [15:0]          fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_W-1:0]     fifo_count;
   logic                 inflight;
   logic                 discard;
   logic [PC_WIDTH-1:0]  head_pc;

   logic [15:0]          head_word;
   logic [15:0]          next_word;
   logic [CNT_W:0]       occupancy;
   logic                 push;
   logic                 load_allowed;
   logic                 load16;
   logic                 load32;
   logic [CNT_W-1:0]     pop_n;

   assign head_word = fifo_mem[rd_ptr];
   assign next_word = fifo_mem[PTR_W'(rd_ptr + 1'b1)];

   // Reads in flight are reserved against FIFO space, so a response can never overflow it.
   assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight);
   assign imem_rd   = !reset && !redirect_valid && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
   assign push      = inflight && !discard && !redirect_valid;

   assign load_allowed = !fetch_valid || decode_ready;
   assign load16       = load_allowed && (fifo_count != '0) && !head_word[15];
   assign load32       = load_allowed && (fifo_count >= CNT_W'(2)) && head_word[15];
   assign pop_n        = load32 ? CNT_W'(2) : (load16 ? CNT_W'(1) : '0);

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr] <= imem_rdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         inflight   <= 1'b0;
         discard    <= 1'b0;
         imem_addr  <= RESET_PC;
      end else begin
         inflight <= imem_rd;
         discard  <= redirect_valid;
         if (redirect_valid) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            imem_addr  <= redirect_pc;
         end else begin
            rd_ptr     <= rd_ptr + PTR_W'(pop_n);
            wr_ptr     <= wr_ptr + PTR_W'(push);
            fifo_count <= fifo_count + CNT_W'(push) - pop_n;
            if (imem_rd) begin
               imem_addr <= imem_addr + 1'b1;
            end
         end
      end
   end

   // Output register holds its contents while the decoder stalls; only fetch_valid drops when starved.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_valid <= 1'b0;
         fetch_instr <= '0;
         fetch_is32  <= 1'b0;
         fetch_pc    <= '0;
         head_pc     <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_valid <= 1'b0;
         head_pc     <= redirect_pc;
      end else if (load_allowed) begin
         if (load16) begin
            fetch_valid <= 1'b1;
            fetch_instr <= {16'h0000, head_word};
            fetch_is32  <= 1'b0;
            fetch_pc    <= head_pc;
            head_pc     <= head_pc + PC_WIDTH'(1);
         end else if (load32) begin
            fetch_valid <= 1'b1;
            fetch_instr <= {next_word, head_word};
            fetch_is32  <= 1'b1;
            fetch_pc    <= head_pc;
            head_pc     <= head_pc + PC_WIDTH'(2);
         end else begin
            fetch_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_instr_count <= '0;
         perf_stall_count <= '0;
      end else if (fetch_valid) begin
         if (decode_ready) begin
            perf_instr_count <= perf_instr_count + 32'd1;
         end else begin
            perf_stall_count <= perf_stall_count + 32'd1;
         end
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_aap_fetch_assembler.sv
// Randomized bench for aap_fetch_assembler against an instruction-stream reference model.
module tb_aap_fetch_assembler;

   localparam int PC_W  = 24;
   localparam int DEPTH = 4;

   logic             clock;
   logic             reset;
   logic             imem_rd;
   logic [PC_W-1:0]  imem_addr;
   logic [15:0]      imem_rdata;
   logic             redirect_valid;
   logic [PC_W-1:0]  redirect_pc;
   logic             fetch_valid;
   logic             decode_ready;
   logic [31:0]      fetch_instr;
   logic             fetch_is32;
   logic [PC_W-1:0]  fetch_pc;
`ifdef FETCH_PERF_EN
   logic [31:0]      perf_instr_count;
   logic [31:0]      perf_stall_count;
`endif

   int               total;
   int               bad;
   int               rd_count;
   logic [15:0]      mem [int];
   logic [15:0]      seed_word;
   logic [PC_W-1:0]  exp_pc;

   aap_fetch_assembler #(.PC_WIDTH(PC_W), .RESET_PC('0), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock),
      .reset(reset),
      .imem_rd(imem_rd),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .fetch_valid(fetch_valid),
      .decode_ready(decode_ready),
      .fetch_instr(fetch_instr),
      .fetch_is32(fetch_is32),
      .fetch_pc(fetch_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_instr_count(perf_instr_count),
      .perf_stall_count(perf_stall_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory contents: explicit words where a test sets them, a seeded hash elsewhere.
   function automatic logic [15:0] mem_val(input logic [PC_W-1:0] a);
      int k;
      k = int'(a);
      if (mem.exists(k)) return mem[k];
      return 16'(k * 40503) ^ seed_word;
   endfunction

   function automatic logic [31:0] model_instr(input logic [PC_W-1:0] p);
      logic [15:0] w0;
      w0 = mem_val(p);
      if (w0[15]) return {mem_val(p + 1'b1), w0};
      return {16'h0000, w0};
   endfunction

   function automatic logic [PC_W-1:0] model_next(input logic [PC_W-1:0] p);
      logic [15:0] w0;
      w0 = mem_val(p);
      return w0[15] ? p + PC_W'(2) : p + PC_W'(1);
   endfunction

   always @(posedge clock) begin
      if (imem_rd) begin
         imem_rdata <= mem_val(imem_addr);
         rd_count   <= rd_count + 1;
      end
   end

   task automatic do_reset();
      @(negedge clock);
      reset          = 1'b1;
      redirect_valid = 1'b0;
      decode_ready   = 1'b0;
      repeat (2) @(negedge clock);
      reset  = 1'b0;
      exp_pc = '0;
   endtask

   // Runs the stream with random ready, optional one or two consecutive redirects, scoring every cycle.
   task automatic run_and_score(input int cycles, input int ready_pct, input int redir_at,
                                input int n_redir, input logic [PC_W-1:0] pc_a,
                                input logic [PC_W-1:0] pc_b);
      int idle;
      logic prev_redir;
      logic [PC_W-1:0] prev_pc;
      idle       = 0;
      prev_redir = 1'b0;
      prev_pc    = '0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clock);
         decode_ready   = ($urandom_range(99) < ready_pct);
         redirect_valid = 1'b0;
         if (n_redir > 0 && c >= redir_at && c < redir_at + n_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = (n_redir == 2 && c == redir_at) ? pc_a : pc_b;
         end
         #1;
         if (redirect_valid) begin
            total++;
            if (imem_rd !== 1'b0) begin
               bad++;
               $display("[TB] FAIL redirect_rd got=%b want=0", imem_rd);
            end
         end
         if (prev_redir && !redirect_valid) begin
            total++;
            if (imem_rd !== 1'b1 || imem_addr !== prev_pc) begin
               bad++;
               $display("[TB] FAIL post_redirect_read got=%b/%h want=1/%h", imem_rd, imem_addr, prev_pc);
            end
         end
         if (fetch_valid) begin
            idle = 0;
            total++;
            if (fetch_instr !== model_instr(exp_pc) || fetch_pc !== exp_pc ||
                fetch_is32 !== mem_val(exp_pc)[15]) begin
               bad++;
               $display("[TB] FAIL stream got=%h/%b/%h want=%h/%b/%h", fetch_instr, fetch_is32,
                        fetch_pc, model_instr(exp_pc), mem_val(exp_pc)[15], exp_pc);
            end
            if (decode_ready) exp_pc = model_next(exp_pc);
         end else begin
            idle++;
            if (idle > 12) begin
               total++;
               bad++;
               $display("[TB] FAIL watchdog got=no_valid want=valid within 12 cycles");
               idle = 0;
            end
         end
         prev_redir = redirect_valid;
         prev_pc    = redirect_pc;
         if (redirect_valid) exp_pc = redirect_pc;
      end
      @(negedge clock);
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] exp_w [3];
      mem.delete();
      mem[0] = 16'h5555; mem[1] = 16'h1234; mem[2] = 16'h0F0F;
      exp_w[0] = 16'h5555; exp_w[1] = 16'h1234; exp_w[2] = 16'h0F0F;
      @(negedge clock);
      reset        = 1'b0;
      decode_ready = 1'b1;
      repeat (4) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      total += 6;
      if (imem_rd !== 1'b0)         begin bad++; $display("[TB] FAIL reset_rd got=%b want=0", imem_rd); end
      if (imem_addr !== '0)         begin bad++; $display("[TB] FAIL reset_addr got=%h want=0", imem_addr); end
      if (fetch_valid !== 1'b0)     begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", fetch_valid); end
      if (fetch_instr !== 32'h0)    begin bad++; $display("[TB] FAIL reset_instr got=%h want=0", fetch_instr); end
      if (fetch_is32 !== 1'b0)      begin bad++; $display("[TB] FAIL reset_is32 got=%b want=0", fetch_is32); end
      if (fetch_pc !== '0)          begin bad++; $display("[TB] FAIL reset_pc got=%h want=0", fetch_pc); end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      total++;
      if (imem_rd !== 1'b1) begin bad++; $display("[TB] FAIL cycle0_rd got=%b want=1", imem_rd); end
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         #1;
         total++;
         if (c < 3) begin
            if (fetch_valid !== 1'b0) begin
               bad++;
               $display("[TB] FAIL latency_c%0d got=%b want=0", c, fetch_valid);
            end
         end else if (fetch_valid !== 1'b1 || fetch_instr !== {16'h0000, exp_w[c-3]} ||
                      fetch_pc !== PC_W'(c - 3) || fetch_is32 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL first_words_c%0d got=%b/%h/%h want=1/%h/%0d", c, fetch_valid,
                     fetch_instr, fetch_pc, {16'h0000, exp_w[c-3]}, c - 3);
         end
      end
   endtask

   task automatic test_is32();
      mem.delete();
      seed_word = 16'($urandom);
      mem[0] = 16'h8001; mem[1] = 16'h7ABC; mem[2] = 16'h0042;
      do_reset();
      run_and_score(25, 100, -10, 0, '0, '0);
   endtask

   task automatic test_stall();
      int base;
      mem.delete();
      seed_word = 16'($urandom);
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom) & 16'h7FFF;
      do_reset();
      base = rd_count;
      for (int i = 0; i < 10 && !fetch_valid; i++) @(negedge clock);
      total++;
      if (!fetch_valid) begin bad++; $display("[TB] FAIL stall_first_valid got=0 want=1"); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         total++;
         if (fetch_valid !== 1'b1 || fetch_instr !== {16'h0000, mem[0]} || fetch_pc !== '0) begin
            bad++;
            $display("[TB] FAIL stall_hold got=%b/%h/%h want=1/%h/0", fetch_valid, fetch_instr,
                     fetch_pc, {16'h0000, mem[0]});
         end
      end
      #1;
      total += 2;
      if (imem_rd !== 1'b0) begin bad++; $display("[TB] FAIL stall_rd got=%b want=0", imem_rd); end
      if (rd_count - base !== DEPTH + 1) begin
         bad++;
         $display("[TB] FAIL stall_reads got=%0d want=%0d", rd_count - base, DEPTH + 1);
      end
      run_and_score(30, 100, -10, 0, '0, '0);
   endtask

   task automatic test_redirect();
      mem.delete();
      seed_word = 16'($urandom);
      do_reset();
      run_and_score(40, 100, 10, 1, '0, 24'h000100);
   endtask

   task automatic test_wrap();
      mem.delete();
      seed_word = 16'($urandom);
      mem[24'hFFFFFF] = 16'h8000;
      mem[0]          = 16'h0001;
      do_reset();
      run_and_score(30, 100, 5, 1, '0, 24'hFFFFFF);
   endtask

   task automatic test_back_to_back();
      mem.delete();
      seed_word = 16'($urandom);
      do_reset();
      run_and_score(40, 70, 8, 2, 24'h000200, 24'h000300);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         mem.delete();
         seed_word = 16'($urandom);
         do_reset();
         run_and_score(60, $urandom_range(30, 90), $urandom_range(5, 40), $urandom_range(1, 2),
                       PC_W'($urandom), PC_W'($urandom));
      end
   endtask

   task automatic test_reset_midstream();
      int vcnt;
      int scnt;
      mem.delete();
      seed_word = 16'($urandom);
      do_reset();
      run_and_score(15, 50, -10, 0, '0, '0);
      #2 reset = 1'b1;
      #1;
      total++;
      if (fetch_valid !== 1'b0 || imem_addr !== '0) begin
         bad++;
         $display("[TB] FAIL midreset got=%b/%h want=0/0", fetch_valid, imem_addr);
      end
      decode_ready = 1'b0;
      repeat (2) @(negedge clock);
      reset  = 1'b0;
      exp_pc = '0;
      vcnt   = 0;
      scnt   = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         decode_ready = (c % 2 == 0);
         #1;
         if (fetch_valid) begin
            vcnt++;
            if (!decode_ready) scnt++;
            total++;
            if (fetch_instr !== model_instr(exp_pc) || fetch_pc !== exp_pc) begin
               bad++;
               $display("[TB] FAIL restart got=%h/%h want=%h/%h", fetch_instr, fetch_pc,
                        model_instr(exp_pc), exp_pc);
            end
            if (decode_ready) exp_pc = model_next(exp_pc);
         end
      end
      @(negedge clock);
      total++;
      if (vcnt == 0) begin bad++; $display("[TB] FAIL restart_progress got=0 want>0"); end
`ifdef FETCH_PERF_EN
      total += 2;
      if (perf_instr_count + perf_stall_count !== 32'(vcnt)) begin
         bad++;
         $display("[TB] FAIL perf_sum got=%0d want=%0d", perf_instr_count + perf_stall_count, vcnt);
      end
      if (perf_stall_count !== 32'(scnt)) begin
         bad++;
         $display("[TB] FAIL perf_stall got=%0d want=%0d", perf_stall_count, scnt);
      end
`endif
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      rd_count       = 0;
      seed_word      = 16'h0000;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      decode_ready   = 1'b0;
      exp_pc         = '0;
      test_reset();
      test_is32();
      test_stall();
      test_redirect();
      test_wrap();
      test_back_to_back();
      test_random();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
